adler32_frame_ctrl: RTL and testbench
=====================================

# adler32_frame_ctrl

Frame-level controller around an Adler-32 accumulator datapath. It accepts a byte stream with valid/ready/last framing and reinitialises the running sums at each frame start. It presents the final checksum and byte count on a result handshake, then rearms for the next frame. It sits between the packet byte stream and the integrity-check logic, replacing free-running accumulation with per-frame sequencing.

## Interface
- LEN_W, 16, width of the frame byte counter; count saturates at 2^LEN_W-1.
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- s_valid  in  1  input byte valid.
- s_ready  out  1  controller can accept a byte.
- s_data  in  8  input byte.
- s_last  in  1  byte is the last of its frame; qualified by s_valid.
- abort  in  1  discard the current frame.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumed.
- m_checksum  out  32  {B[15:0], A[15:0]} of the completed frame.
- m_length  out  LEN_W  bytes in the frame, saturating.
- m_overflow  out  1  frame exceeded 2^LEN_W-1 bytes.
- busy  out  1  frame in progress or result pending.

## Operation
- States: IDLE, ACCUM, RESULT.
- A byte is accepted when s_valid && s_ready.
- s_ready = 1 in IDLE and ACCUM, 0 in RESULT, 0 while rst_n low.
- IDLE: A=0x0001, B=0x0000, count=0.
  - Accepted byte with !s_last -> ACCUM.
  - Accepted byte with s_last -> RESULT.
- ACCUM: each accepted byte updates A, B and count.
  - Accepted s_last byte -> RESULT.
- RESULT: m_valid=1, outputs held stable. m_valid && m_ready -> IDLE with A=1, B=0, count=0.
- Arithmetic uses 17-bit intermediates with modulus M=65521:
  - a = A + s_data; A' = (a >= M) ? a-M : a.
  - b = B + A'; B' = (b >= M) ? b-M : b.
  - Comparison is >=, never >. A and B stay in 0..65520.
- Count increments per accepted byte and saturates at 2^LEN_W-1. m_overflow sets if a byte is accepted while count is already saturated, and clears on return to IDLE.
- abort in IDLE or ACCUM: next state IDLE, sums and count reinitialised, any byte accepted that cycle discarded, no result produced.
- abort in RESULT is ignored.
- busy = (state != IDLE).
- Frames are never empty: s_last always accompanies a byte.

## Timing
- Reset values: m_valid=0, m_checksum=0x00000001, m_length=0, m_overflow=0, busy=0, state IDLE.
- Sums are registered, and the update completes in one cycle per byte. Full throughput is one byte per clock.
- Latency: m_valid rises the cycle after the s_last byte is accepted, carrying that byte's contribution.
- Earliest next-frame byte: the cycle after m_valid && m_ready. s_ready rises in that cycle.
- m_checksum/m_length/m_overflow outputs:
  - Registered, and stable while m_valid=1.
  - In IDLE/ACCUM they reflect the running values and are don't-care to consumers.
- Simultaneous abort and s_last byte: abort wins and no result is produced.
- rst_n low mid-frame or in RESULT: state returns to IDLE on the next edge and the pending result is dropped.

## Configuration
- ADLER32_FRAME_CHECK_EN defined:
  - Adds input exp_checksum[31:0], sampled with the s_last byte.
  - Adds output m_match: 1 when the final checksum equals the sampled value. Reset 0, valid with m_valid.
- Not defined: the ports do not exist and there is no compare logic.

## Test plan
- Reset, then single byte 0x61 with s_last -> next cycle m_valid=1, m_checksum=0x00620062, m_length=1, busy=1.
- "Wikipedia" (9 bytes) back-to-back, then m_ready=1 -> m_checksum=0x11E60398, m_length=9. IDLE follows, and the next byte 0x00 alone gives 0x00010001.
- 300 bytes of 0xFF:
  - A wraps modulo 65521: A field 0x2AE4, B field equal to the software model, m_length=300.
  - Random s_valid gaps and m_ready delay give identical results.
- LEN_W=4, 20-byte frame -> m_length=15, m_overflow=1. Overflow clears for the following 3-byte frame.
- abort asserted mid-frame after "xy", then "abc" + last -> m_checksum=0x024D0127, m_length=3. abort held during RESULT leaves outputs unchanged.
- With ADLER32_FRAME_CHECK_EN:
  - exp_checksum=0x024D0127 on "abc" gives m_match=1.
  - 0x024D0128 gives m_match=0.
  - rst_n low during RESULT gives m_valid=0 next cycle.

Source files
------------

// File: rtl/adler32_frame_ctrl_if.sv
// Byte-stream and result-handshake bundle for adler32_frame_ctrl.
// ADLER32_FRAME_CHECK_EN adds exp_checksum/m_match for the expected-checksum compare.
interface adler32_frame_ctrl_if #(
  parameter int LEN_W = 16
);
  // Handshake: a transfer happens on a rising clk edge where valid && ready.
  // valid must not wait on ready, and payload is held stable while valid && !ready.
  logic             s_valid;
  logic             s_ready;
  logic [7:0]       s_data;
  logic             s_last;
  logic             abort;
  logic             m_valid;
  logic             m_ready;
  logic [31:0]      m_checksum;
  logic [LEN_W-1:0] m_length;
  logic             m_overflow;
  logic             busy;
  logic [1:0]       dbg_state;
`ifdef ADLER32_FRAME_CHECK_EN
  logic [31:0]      exp_checksum;
  logic             m_match;

  modport master (
    output s_valid, s_data, s_last, abort, m_ready, exp_checksum,
    input  s_ready, m_valid, m_checksum, m_length, m_overflow, busy, dbg_state, m_match
  );
  modport slave (
    input  s_valid, s_data, s_last, abort, m_ready, exp_checksum,
    output s_ready, m_valid, m_checksum, m_length, m_overflow, busy, dbg_state, m_match
  );
`else
  modport master (
    output s_valid, s_data, s_last, abort, m_ready,
    input  s_ready, m_valid, m_checksum, m_length, m_overflow, busy, dbg_state
  );
  modport slave (
    input  s_valid, s_data, s_last, abort, m_ready,
    output s_ready, m_valid, m_checksum, m_length, m_overflow, busy, dbg_state
  );
`endif
endinterface

// File: rtl/adler32_frame_ctrl.sv
// Per-frame Adler-32 sequencer: sums restart at each frame, result held until consumed.
// Optional ADLER32_FRAME_CHECK_EN compares the final checksum against exp_checksum.
module adler32_frame_ctrl #(
  parameter int LEN_W = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  adler32_frame_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } state_t;

  localparam logic [16:0]      MOD     = 17'd65521;
  localparam logic [LEN_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  logic [15:0]      r_a;
  logic [15:0]      r_b;
  logic [LEN_W-1:0] r_count;
  logic             r_ovf;

  logic             w_s_ready;
  logic             w_accept;
  logic [16:0]      w_a_sum;
  logic [16:0]      w_a_red;
  logic [15:0]      w_a_next;
  logic [16:0]      w_b_sum;
  logic [16:0]      w_b_red;
  logic [15:0]      w_b_next;
  logic             w_cnt_sat;

  assign w_s_ready = rst_n && (r_state != RESULT);
  assign w_accept  = bus.s_valid && w_s_ready;

  // Both sums stay below M, so one conditional subtract is a full reduction.
  assign w_a_sum  = {1'b0, r_a} + {9'd0, bus.s_data};
  assign w_a_red  = w_a_sum - MOD;
  assign w_a_next = (w_a_sum >= MOD) ? w_a_red[15:0] : w_a_sum[15:0];
  assign w_b_sum  = {1'b0, r_b} + {1'b0, w_a_next};
  assign w_b_red  = w_b_sum - MOD;
  assign w_b_next = (w_b_sum >= MOD) ? w_b_red[15:0] : w_b_sum[15:0];

  assign w_cnt_sat = (r_count == CNT_MAX);

`ifdef ADLER32_FRAME_CHECK_EN
  logic r_match;
  assign bus.m_match = r_match;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= 16'd1;
      r_b     <= 16'd0;
      r_count <= '0;
      r_ovf   <= 1'b0;
`ifdef ADLER32_FRAME_CHECK_EN
      r_match <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, ACCUM: begin
          if (bus.abort) begin
            // abort beats a same-cycle byte, including an s_last byte
            r_state <= IDLE;
            r_a     <= 16'd1;
            r_b     <= 16'd0;
            r_count <= '0;
            r_ovf   <= 1'b0;
`ifdef ADLER32_FRAME_CHECK_EN
            r_match <= 1'b0;
`endif
          end else if (w_accept) begin
            r_a <= w_a_next;
            r_b <= w_b_next;
            if (w_cnt_sat) r_ovf <= 1'b1;
            else           r_count <= r_count + 1'b1;
            if (bus.s_last) begin
              r_state <= RESULT;
`ifdef ADLER32_FRAME_CHECK_EN
              r_match <= ({w_b_next, w_a_next} == bus.exp_checksum);
`endif
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        RESULT: begin
          if (bus.m_ready) begin
            r_state <= IDLE;
            r_a     <= 16'd1;
            r_b     <= 16'd0;
            r_count <= '0;
            r_ovf   <= 1'b0;
`ifdef ADLER32_FRAME_CHECK_EN
            r_match <= 1'b0;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.s_ready    = w_s_ready;
  assign bus.m_valid    = (r_state == RESULT);
  assign bus.m_checksum = {r_b, r_a};
  assign bus.m_length   = r_count;
  assign bus.m_overflow = r_ovf;
  assign bus.busy       = (r_state != IDLE);
  assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_adler32_frame_ctrl.sv
// Directed bench for adler32_frame_ctrl: default DUT plus a LEN_W=4 copy in lockstep.
// Both DUTs share one stimulus set so the saturation case rides along every frame.
module tb_adler32_frame_ctrl;
  logic clk;
  logic rst_n;
  logic s_valid;
  logic [7:0] s_data;
  logic s_last;
  logic abort;
  logic m_ready;
`ifdef ADLER32_FRAME_CHECK_EN
  logic [31:0] exp_checksum;
`endif

  int n_checks = 0;
  int n_err    = 0;

  adler32_frame_ctrl_if #(.LEN_W(16)) bus ();
  adler32_frame_ctrl_if #(.LEN_W(4))  bus4 ();

  assign bus.s_valid  = s_valid;
  assign bus.s_data   = s_data;
  assign bus.s_last   = s_last;
  assign bus.abort    = abort;
  assign bus.m_ready  = m_ready;
  assign bus4.s_valid = s_valid;
  assign bus4.s_data  = s_data;
  assign bus4.s_last  = s_last;
  assign bus4.abort   = abort;
  assign bus4.m_ready = m_ready;
`ifdef ADLER32_FRAME_CHECK_EN
  assign bus.exp_checksum  = exp_checksum;
  assign bus4.exp_checksum = exp_checksum;
`endif

  adler32_frame_ctrl #(.LEN_W(16)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
  adler32_frame_ctrl #(.LEN_W(4))  dut_4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // drivers: called at a negedge, return at the negedge after the accepting edge
  task automatic send_byte(input logic [7:0] d, input logic last);
    int   n;
    logic rdy;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    rdy = bus.s_ready;
    while (!rdy && n < 20) begin
      @(negedge clk);
      rdy = bus.s_ready;
      n++;
    end
    if (!rdy) chk("send_ready_timeout", {31'd0, rdy}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    while (!bus.m_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("m_valid_seen", {31'd0, bus.m_valid}, 32'd1);
  endtask

  task automatic consume(input int delay);
    logic [31:0] held;
    held = bus.m_checksum;
    repeat (delay) @(negedge clk);
    chk("held_checksum", bus.m_checksum, held);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("after_consume_m_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("after_consume_busy", {31'd0, bus.busy}, 32'd0);
  endtask

  logic [7:0] wiki [9];
  logic [7:0] abc  [3];

  initial begin
    wiki = '{8'h57, 8'h69, 8'h6B, 8'h69, 8'h70, 8'h65, 8'h64, 8'h69, 8'h61};
    abc  = '{8'h61, 8'h62, 8'h63};
    rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    abort = 1'b0; m_ready = 1'b0;
`ifdef ADLER32_FRAME_CHECK_EN
    exp_checksum = 32'h0;
`endif

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_s_ready", {31'd0, bus.s_ready}, 32'd0);
    chk("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("rst_checksum", bus.m_checksum, 32'h0000_0001);
    chk("rst_length", {16'd0, bus.m_length}, 32'd0);
    chk("rst_overflow", {31'd0, bus.m_overflow}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
`ifdef ADLER32_FRAME_CHECK_EN
    chk("rst_match", {31'd0, bus.m_match}, 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_s_ready", {31'd0, bus.s_ready}, 32'd1);

    // single byte frame, one-cycle latency
    send_byte(8'h61, 1'b1);
    chk("a_m_valid", {31'd0, bus.m_valid}, 32'd1);
    chk("a_checksum", bus.m_checksum, 32'h0062_0062);
    chk("a_length", {16'd0, bus.m_length}, 32'd1);
    chk("a_busy", {31'd0, bus.busy}, 32'd1);
    chk("a_s_ready_result", {31'd0, bus.s_ready}, 32'd0);
    consume(0);

    // Wikipedia, back-to-back
    for (int i = 0; i < 9; i++) send_byte(wiki[i], (i == 8));
    wait_result();
    chk("wiki_checksum", bus.m_checksum, 32'h11E6_0398);
    chk("wiki_length", {16'd0, bus.m_length}, 32'd9);
    consume(0);
    chk("wiki_idle_state", {30'd0, bus.dbg_state}, 32'd0);
    chk("wiki_next_s_ready", {31'd0, bus.s_ready}, 32'd1);
    send_byte(8'h00, 1'b1);
    wait_result();
    chk("zero_checksum", bus.m_checksum, 32'h0001_0001);
    consume(1);

    // 300 x 0xFF, A wraps: A=76501-65521=0x2AE4, B=11513550 mod 65521=0xB90F
    for (int i = 0; i < 300; i++) send_byte(8'hFF, (i == 299));
    wait_result();
    chk("ff_checksum", bus.m_checksum, 32'hB90F_2AE4);
    chk("ff_length", {16'd0, bus.m_length}, 32'd300);
    chk("ff_overflow", {31'd0, bus.m_overflow}, 32'd0);
    consume(0);

    // same frame with random gaps and delayed m_ready
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_byte(8'hFF, (i == 299));
    end
    wait_result();
    chk("ff_gap_checksum", bus.m_checksum, 32'hB90F_2AE4);
    chk("ff_gap_length", {16'd0, bus.m_length}, 32'd300);
    consume($urandom_range(1, 4));

    // 20 x 0x01: A=21, B=20+210=230; LEN_W=4 copy saturates at 15
    for (int i = 0; i < 20; i++) send_byte(8'h01, (i == 19));
    wait_result();
    chk("sat_checksum", bus4.m_checksum, 32'h00E6_0015);
    chk("sat_length4", {28'd0, bus4.m_length}, 32'd15);
    chk("sat_overflow4", {31'd0, bus4.m_overflow}, 32'd1);
    chk("sat_length16", {16'd0, bus.m_length}, 32'd20);
    chk("sat_overflow16", {31'd0, bus.m_overflow}, 32'd0);
    consume(0);
    chk("sat_overflow4_idle", {31'd0, bus4.m_overflow}, 32'd0);
    for (int i = 0; i < 3; i++) send_byte(abc[i], (i == 2));
    wait_result();
    chk("post_sat_length4", {28'd0, bus4.m_length}, 32'd3);
    chk("post_sat_overflow4", {31'd0, bus4.m_overflow}, 32'd0);
    chk("post_sat_checksum4", bus4.m_checksum, 32'h024D_0127);
    consume(0);

    // abort mid-frame after "xy"
    send_byte(8'h78, 1'b0);
    send_byte(8'h79, 1'b0);
    chk("xy_busy", {31'd0, bus.busy}, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_checksum", bus.m_checksum, 32'h0000_0001);
    chk("abort_length", {16'd0, bus.m_length}, 32'd0);

    // abort together with an s_last byte: no result
    send_byte(8'h7A, 1'b0);
    abort = 1'b1; s_valid = 1'b1; s_data = 8'h7A; s_last = 1'b1;
    @(negedge clk);
    abort = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    chk("abort_last_m_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("abort_last_busy", {31'd0, bus.busy}, 32'd0);

    for (int i = 0; i < 3; i++) send_byte(abc[i], (i == 2));
    wait_result();
    chk("abc_checksum", bus.m_checksum, 32'h024D_0127);
    chk("abc_length", {16'd0, bus.m_length}, 32'd3);

    // abort during RESULT is ignored
    abort = 1'b1;
    repeat (2) @(negedge clk);
    chk("result_abort_m_valid", {31'd0, bus.m_valid}, 32'd1);
    chk("result_abort_checksum", bus.m_checksum, 32'h024D_0127);
    chk("result_abort_length", {16'd0, bus.m_length}, 32'd3);
    abort = 1'b0;
    consume(0);

`ifdef ADLER32_FRAME_CHECK_EN
    exp_checksum = 32'h024D_0127;
    for (int i = 0; i < 3; i++) send_byte(abc[i], (i == 2));
    wait_result();
    chk("match_hit", {31'd0, bus.m_match}, 32'd1);
    consume(0);
    exp_checksum = 32'h024D_0128;
    for (int i = 0; i < 3; i++) send_byte(abc[i], (i == 2));
    wait_result();
    chk("match_miss", {31'd0, bus.m_match}, 32'd0);
    consume(0);
`endif

    // reset while a result is pending drops it
    for (int i = 0; i < 3; i++) send_byte(abc[i], (i == 2));
    wait_result();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_result_m_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("rst_result_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_result_s_ready", {31'd0, bus.s_ready}, 32'd0);
    chk("rst_result_checksum", bus.m_checksum, 32'h0000_0001);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_s_ready", {31'd0, bus.s_ready}, 32'd1);

    // final report
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
